am_trainer: RTL and testbench

- Training-side counterpart of the associative memory.
- Accepts labelled query hypervectors and bundles them per class into signed per-bit saturating counters.
- On command, majority-thresholds the counters and streams one prototype hypervector per class to the associative-memory loader.
- Updates run in `CHUNK`-bit slices over `CYCLELOOP` cycles, matching the classifier's chunked datapath.

---
 rtl/am_pkg.sv | 38 +++
 rtl/am_trainer_chunk_update.sv | 39 +++
 rtl/am_trainer.sv | 202 ++++++++++++++++++++
 tb/tb_am_trainer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// am_pkg: definitions shared by the associative-memory blocks.
//   - trainerCmd_t   : command encodings (TRAIN, EMIT, CLEAR, NOP)
//   - trainerState_t : trainer FSM states
//   - *_DEF          : default hypervector / chunk / counter / class sizes
//   - ceilLog2()     : constant helper for sizing index registers
package am_pkg;

    localparam int HV_DIMENSION_DEF = 2048;
    localparam int CHUNK_DEF        = 256;
    localparam int CNT_WIDTH_DEF    = 8;
    localparam int CLASSES_DEF      = 2;
    localparam int LABEL_WIDTH_DEF  = 1;

    typedef enum logic [1:0] {
        CMD_TRAIN = 2'b00,
        CMD_EMIT  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_NOP   = 2'b11
    } trainerCmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUMULATE,
        ST_LOAD,
        ST_OUTPUT_STABLE
    } trainerState_t;

    // Smallest r with 2**r >= value.
    function automatic int ceilLog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/am_trainer_chunk_update.sv
// am_trainer_chunk_update: combinational saturating +/-1 update of one
// CHUNK-wide slice of signed per-bit counters.
// Ports:
//   cntCur     in   CHUNK*CNT_WIDTH  current counters, element j at [j*CNT_WIDTH +: CNT_WIDTH]
//   sampleBits in   CHUNK            sample bits; 1 -> increment, 0 -> decrement
//   cntNext    out  CHUNK*CNT_WIDTH  updated counters, saturated to the signed range
module am_trainer_chunk_update #(
    parameter int CHUNK     = 256,
    parameter int CNT_WIDTH = 8
) (
    input  logic [CHUNK*CNT_WIDTH-1:0] cntCur,
    input  logic [CHUNK-1:0]           sampleBits,
    output logic [CHUNK*CNT_WIDTH-1:0] cntNext
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cur;

    // NOTE: combinational logic uses blocking '=' so each iteration sees the
    // value just computed; clocked state elsewhere uses non-blocking '<='.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a bit unassigned and no latch is inferred.
        cntNext = '0;
        cur     = '0;
        for (int j = 0; j < CHUNK; j++) begin
            cur = cntCur[j*CNT_WIDTH +: CNT_WIDTH];
            if (sampleBits[j]) begin
                cntNext[j*CNT_WIDTH +: CNT_WIDTH] = (cur == CNT_MAX) ? cur : cur + CNT_ONE;
            end else begin
                cntNext[j*CNT_WIDTH +: CNT_WIDTH] = (cur == CNT_MIN) ? cur : cur - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/am_trainer.sv
// am_trainer: training side of the associative memory. Bundles labelled
// hypervectors into signed saturating per-bit counters (one set per class),
// CHUNK bits per cycle, and on EMIT streams a majority-thresholded prototype
// per class to the associative-memory loader.
// Ports:
//   Clk_CI, Reset_RBI            clock (rising edge), async active-low reset
//   ValidIn_SI / ReadyOut_SO     command handshake; ready only in IDLE
//   CmdIn_SI                     00 TRAIN, 01 EMIT, 10 CLEAR, 11 NOP
//   HypervectorIn_DI, LabelIn_DI training sample [0:N-1] (bit 0 = MSB side) and class
//   ValidOut_SO / ReadyIn_SI     prototype handshake
//   PrototypeOut_DO, LabelOut_DO, LastOut_SO  registered prototype, class index, last flag
// Build option: define AM_TRAINER_TIEBREAK_EN to resolve zero counters to
// 1 on even bit indices and 0 on odd ones; otherwise zero counters give 0.
module am_trainer
    import am_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int CLASSES      = CLASSES_DEF,
    parameter int LABEL_WIDTH  = LABEL_WIDTH_DEF,
    parameter int CHUNK        = CHUNK_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RBI,
    input  logic                     ValidIn_SI,
    output logic                     ReadyOut_SO,
    input  logic [1:0]               CmdIn_SI,
    input  logic [0:HV_DIMENSION-1]  HypervectorIn_DI,
    input  logic [LABEL_WIDTH-1:0]   LabelIn_DI,
    output logic                     ValidOut_SO,
    input  logic                     ReadyIn_SI,
    output logic [0:HV_DIMENSION-1]  PrototypeOut_DO,
    output logic [LABEL_WIDTH-1:0]   LabelOut_DO,
    output logic                     LastOut_SO
);

    localparam int CYCLELOOP = HV_DIMENSION / CHUNK;
    localparam int CLS_W     = (CLASSES > 1) ? ceilLog2(CLASSES) : 1;
    localparam int CHK_W     = (CYCLELOOP > 1) ? ceilLog2(CYCLELOOP) : 1;

    localparam logic [CHK_W-1:0] LAST_CHUNK = CHK_W'(CYCLELOOP - 1);
    localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(CLASSES - 1);

    trainerState_t             state;
    logic [CLS_W-1:0]          classIdx;   // training label, or emission index
    logic [CHK_W-1:0]          chunkIdx;
    logic [0:HV_DIMENSION-1]   sampleReg;

    logic [CNT_WIDTH-1:0]      counters [CLASSES][HV_DIMENSION];

    logic [CHUNK*CNT_WIDTH-1:0] sliceCur;
    logic [CHUNK*CNT_WIDTH-1:0] sliceNext;
    logic [CHUNK-1:0]           sliceSample;
    logic [0:HV_DIMENSION-1]    protoNext;

    logic idleAccept;
    logic labelOk;

    assign idleAccept = (state == ST_IDLE) && ValidIn_SI;
    assign labelOk    = 32'(LabelIn_DI) < 32'(CLASSES);

    // Zero counters resolve to the configured tie value.
    function automatic logic thresholdBit(input logic [CNT_WIDTH-1:0] cnt, input int idx);
        if (cnt == '0) begin
`ifdef AM_TRAINER_TIEBREAK_EN
            return (idx % 2) == 0;
`else
            return 1'b0;
`endif
        end
        return ~cnt[CNT_WIDTH-1];
    endfunction

    // Select the active class/chunk slice of counters and sample bits.
    always_comb begin
        sliceCur    = '0;
        sliceSample = '0;
        for (int k = 0; k < CYCLELOOP; k++) begin
            if (chunkIdx == CHK_W'(k)) begin
                for (int j = 0; j < CHUNK; j++) begin
                    sliceSample[j] = sampleReg[k*CHUNK + j];
                    for (int c = 0; c < CLASSES; c++) begin
                        if (classIdx == CLS_W'(c)) begin
                            sliceCur[j*CNT_WIDTH +: CNT_WIDTH] = counters[c][k*CHUNK + j];
                        end
                    end
                end
            end
        end
    end

    am_trainer_chunk_update #(
        .CHUNK     (CHUNK),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_chunkUpdate (
        .cntCur     (sliceCur),
        .sampleBits (sliceSample),
        .cntNext    (sliceNext)
    );

    // Majority threshold of the class currently selected for emission.
    always_comb begin
        protoNext = '0;
        for (int c = 0; c < CLASSES; c++) begin
            if (classIdx == CLS_W'(c)) begin
                for (int i = 0; i < HV_DIMENSION; i++) begin
                    protoNext[i] = thresholdBit(counters[c][i], i);
                end
            end
        end
    end

    // NOTE: the counter array is built from flops rather than a RAM because
    // reset and CLEAR must zero every counter in a single edge.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            for (int c = 0; c < CLASSES; c++) begin
                for (int i = 0; i < HV_DIMENSION; i++) counters[c][i] <= '0;
            end
        end else if (idleAccept && (trainerCmd_t'(CmdIn_SI) == CMD_CLEAR)) begin
            for (int c = 0; c < CLASSES; c++) begin
                for (int i = 0; i < HV_DIMENSION; i++) counters[c][i] <= '0;
            end
        end else if (state == ST_ACCUMULATE) begin
            for (int c = 0; c < CLASSES; c++) begin
                for (int i = 0; i < HV_DIMENSION; i++) begin
                    if ((classIdx == CLS_W'(c)) && (chunkIdx == CHK_W'(i / CHUNK))) begin
                        counters[c][i] <= sliceNext[(i % CHUNK)*CNT_WIDTH +: CNT_WIDTH];
                    end
                end
            end
        end
    end

    // Control FSM with registered handshake and prototype outputs.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state           <= ST_IDLE;
            classIdx        <= '0;
            chunkIdx        <= '0;
            sampleReg       <= '0;
            ReadyOut_SO     <= 1'b1;
            ValidOut_SO     <= 1'b0;
            PrototypeOut_DO <= '0;
            LabelOut_DO     <= '0;
            LastOut_SO      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ValidIn_SI) begin
                        case (trainerCmd_t'(CmdIn_SI))
                            CMD_TRAIN: begin
                                // Out-of-range labels are dropped without leaving IDLE.
                                if (labelOk) begin
                                    sampleReg   <= HypervectorIn_DI;
                                    classIdx    <= LabelIn_DI[CLS_W-1:0];
                                    chunkIdx    <= '0;
                                    ReadyOut_SO <= 1'b0;
                                    state       <= ST_ACCUMULATE;
                                end
                            end
                            CMD_EMIT: begin
                                classIdx    <= '0;
                                ReadyOut_SO <= 1'b0;
                                state       <= ST_LOAD;
                            end
                            default: ;  // CLEAR acts on the counters only; NOP does nothing
                        endcase
                    end
                end
                ST_ACCUMULATE: begin
                    chunkIdx <= chunkIdx + CHK_W'(1);
                    if (chunkIdx == LAST_CHUNK) begin
                        ReadyOut_SO <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    PrototypeOut_DO <= protoNext;
                    LabelOut_DO     <= LABEL_WIDTH'(classIdx);
                    LastOut_SO      <= (classIdx == LAST_CLASS);
                    ValidOut_SO     <= 1'b1;
                    state           <= ST_OUTPUT_STABLE;
                end
                ST_OUTPUT_STABLE: begin
                    if (ReadyIn_SI) begin
                        ValidOut_SO <= 1'b0;
                        if (LastOut_SO) begin
                            ReadyOut_SO <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            classIdx <= classIdx + CLS_W'(1);
                            state    <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_trainer.sv
module tb_am_trainer;
    import am_pkg::*;

    localparam int HV  = 2048;
    localparam int CLS = 2;
    localparam int LW  = 2;   // wide enough to present an out-of-range label
    localparam int CH  = 256;
    localparam int CW  = 8;
    localparam int CYC = HV / CH;
    localparam int CMAX = (1 << (CW - 1)) - 1;
    localparam int CMIN = -(1 << (CW - 1));

    logic           Clk_CI = 1'b0;
    logic           Reset_RBI = 1'b0;
    logic           ValidIn_SI = 1'b0;
    logic           ReadyOut_SO;
    logic [1:0]     CmdIn_SI = CMD_NOP;
    logic [0:HV-1]  HypervectorIn_DI = '0;
    logic [LW-1:0]  LabelIn_DI = '0;
    logic           ValidOut_SO;
    logic           ReadyIn_SI = 1'b1;
    logic [0:HV-1]  PrototypeOut_DO;
    logic [LW-1:0]  LabelOut_DO;
    logic           LastOut_SO;

    am_trainer #(
        .HV_DIMENSION (HV),
        .CLASSES      (CLS),
        .LABEL_WIDTH  (LW),
        .CHUNK        (CH),
        .CNT_WIDTH    (CW)
    ) dut (
        .Clk_CI           (Clk_CI),
        .Reset_RBI        (Reset_RBI),
        .ValidIn_SI       (ValidIn_SI),
        .ReadyOut_SO      (ReadyOut_SO),
        .CmdIn_SI         (CmdIn_SI),
        .HypervectorIn_DI (HypervectorIn_DI),
        .LabelIn_DI       (LabelIn_DI),
        .ValidOut_SO      (ValidOut_SO),
        .ReadyIn_SI       (ReadyIn_SI),
        .PrototypeOut_DO  (PrototypeOut_DO),
        .LabelOut_DO      (LabelOut_DO),
        .LastOut_SO       (LastOut_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: plain integer vote counts ----------------
    int model [CLS][HV];

    typedef struct {
        logic [0:HV-1] proto;
        int            label;
        bit            last;
    } exp_t;
    exp_t expq[$];

    function automatic logic tie_bit(input int i);
`ifdef AM_TRAINER_TIEBREAK_EN
        return (i % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CLS; c++)
            for (int i = 0; i < HV; i++) model[c][i] = 0;
    endtask

    task automatic model_train(input logic [0:HV-1] hv, input int label);
        int v;
        if (label >= CLS) return;
        for (int i = 0; i < HV; i++) begin
            v = model[label][i] + (hv[i] ? 1 : -1);
            if (v > CMAX) v = CMAX;
            if (v < CMIN) v = CMIN;
            model[label][i] = v;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        for (int c = 0; c < CLS; c++) begin
            for (int i = 0; i < HV; i++)
                e.proto[i] = (model[c][i] > 0) ? 1'b1 : (model[c][i] < 0) ? 1'b0 : tie_bit(i);
            e.label = c;
            e.last  = (c == CLS - 1);
            expq.push_back(e);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit            held = 0;
    logic [0:HV-1] heldProto;
    logic [LW-1:0] heldLabel;
    logic          heldLast;

    always @(negedge Clk_CI) begin
        exp_t e;
        logic [0:HV-1] diff;
        int first;
        if (!Reset_RBI) begin
            held = 0;
        end else begin
            if (held) begin
                check("hold_valid", ValidOut_SO, 1);
                check("hold_label", LabelOut_DO, heldLabel);
                check("hold_last", LastOut_SO, heldLast);
                check("hold_proto_same", PrototypeOut_DO == heldProto, 1);
            end
            if (ValidOut_SO) begin
                check("ready_low_while_valid", ReadyOut_SO, 0);
                if (ReadyIn_SI) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_proto: got label %0d, expected no output", LabelOut_DO);
                    end else begin
                        e = expq.pop_front();
                        check("proto_label", LabelOut_DO, e.label);
                        check("proto_last", LastOut_SO, e.last);
                        diff = PrototypeOut_DO ^ e.proto;
                        checks++;
                        if ($countones(diff) != 0) begin
                            first = -1;
                            for (int i = HV - 1; i >= 0; i--) if (diff[i]) first = i;
                            failures++;
                            $display("FAIL proto_class%0d: %0d bits differ, first bit %0d got %b expected %b",
                                     e.label, $countones(diff), first, PrototypeOut_DO[first], e.proto[first]);
                        end
                    end
                end
                held      = !ReadyIn_SI;
                heldProto = PrototypeOut_DO;
                heldLabel = LabelOut_DO;
                heldLast  = LastOut_SO;
            end else begin
                held = 0;
            end
        end
    end

    // ---------------- stimulus helpers (entered at posedge + #1) ----------------
    task automatic send(input logic [1:0] cmd, input logic [0:HV-1] hv, input logic [LW-1:0] lab);
        int guard = 0;
        while (!ReadyOut_SO && guard < 200) begin
            @(posedge Clk_CI); #1;
            guard++;
        end
        if (!ReadyOut_SO) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout: ReadyOut_SO got 0 expected 1 within 200 cycles");
        end
        ValidIn_SI       = 1'b1;
        CmdIn_SI         = cmd;
        HypervectorIn_DI = hv;
        LabelIn_DI       = lab;
        @(posedge Clk_CI); #1;
        ValidIn_SI       = 1'b0;
        CmdIn_SI         = CMD_NOP;
        HypervectorIn_DI = $urandom();   // must not matter once accepted
        LabelIn_DI       = LW'($urandom());
    endtask

    task automatic train(input logic [0:HV-1] hv, input int label);
        model_train(hv, label);
        send(CMD_TRAIN, hv, LW'(label));
    endtask

    task automatic clear();
        model_clear();
        send(CMD_CLEAR, '0, '0);
    endtask

    task automatic drain(input bit random_bp);
        int guard = 0;
        while (expq.size() != 0 && guard < 500) begin
            ReadyIn_SI = random_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge Clk_CI); #1;
            guard++;
        end
        ReadyIn_SI = 1'b1;
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL emit_timeout: %0d prototypes outstanding, expected 0", expq.size());
            expq.delete();
        end else begin
            check("ready_after_emit", ReadyOut_SO, 1);
        end
    endtask

    task automatic emit(input bit random_bp);
        push_expect();
        send(CMD_EMIT, '0, '0);
        drain(random_bp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, ReadyOut_SO, 1);
        check({tag, "_valid"}, ValidOut_SO, 0);
        check({tag, "_proto_ones"}, $countones(PrototypeOut_DO), 0);
        check({tag, "_label"}, LabelOut_DO, 0);
        check({tag, "_last"}, LastOut_SO, 0);
    endtask

    function automatic logic [0:HV-1] rand_hv();
        logic [0:HV-1] hv;
        for (int w = 0; w < HV / 32; w++) hv[w*32 +: 32] = $urandom();
        return hv;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:HV-1] ones, pat_a;
        int n;

        for (int i = 0; i < HV; i++) begin
            ones[i]  = 1'b1;
            pat_a[i] = (i % 8) < 4;   // 0xF0 repeated, MSB first
        end
        model_clear();

        // Reset state.
        #12;
        check_reset_values("reset");
        @(posedge Clk_CI); #1;
        Reset_RBI = 1'b1;
        @(posedge Clk_CI); #1;

        // Single sample, with TRAIN occupancy measured.
        model_train(ones, 0);
        send(CMD_TRAIN, ones, 0);
        check("ready_low_during_train", ReadyOut_SO, 0);
        n = 0;
        while (!ReadyOut_SO && n < 50) begin
            @(posedge Clk_CI); #1;
            n++;
        end
        check("train_latency", n, CYC);
        emit(1'b0);

        // Majority vote: A, A, ~A into class 1.
        clear();
        train(pat_a, 1);
        train(pat_a, 1);
        train(~pat_a, 1);
        emit(1'b1);

        // Out-of-range label is dropped at once.
        send(CMD_TRAIN, ones, LW'(3));
        check("invalid_label_ready", ReadyOut_SO, 1);
        send(CMD_NOP, ones, 0);
        check("nop_ready", ReadyOut_SO, 1);
        emit(1'b0);

        // Saturation: +127 ceiling, then 127 decrements land exactly on zero.
        clear();
        for (int k = 0; k < 200; k++) train(ones, 0);
        for (int k = 0; k < 127; k++) train('0, 0);
        emit(1'b0);

        // Back-pressure on the first prototype.
        train(rand_hv(), 0);
        train(rand_hv(), 1);
        push_expect();
        ReadyIn_SI = 1'b0;
        send(CMD_EMIT, '0, '0);
        n = 0;
        while (!ValidOut_SO && n < 10) begin
            @(posedge Clk_CI); #1;
            n++;
        end
        check("emit_first_valid_bound", n <= 2, 1);
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk_CI); #1;
            check("bp_valid", ValidOut_SO, 1);
            check("bp_ready_out", ReadyOut_SO, 0);
            check("bp_label", LabelOut_DO, 0);
        end
        ReadyIn_SI = 1'b1;
        @(posedge Clk_CI); #1;   // handshake edge
        check("bubble_after_handshake", ValidOut_SO, 0);
        @(posedge Clk_CI); #1;
        check("next_class_valid", ValidOut_SO, 1);
        check("next_class_label", LabelOut_DO, 1);
        drain(1'b0);

        // Reset while chunk 3 is being accumulated.
        send(CMD_TRAIN, ones, 1);
        repeat (3) @(posedge Clk_CI);
        #1;
        Reset_RBI = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge Clk_CI); #1;
        Reset_RBI = 1'b1;
        model_clear();
        @(posedge Clk_CI); #1;
        emit(1'b1);

        // Randomised mix, including out-of-range labels and clears.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++) train(rand_hv(), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) clear();
            emit(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
